robo_navegador: RTL and testbench

//  Parametrised navigation controller for the pipe-cleaner robot. It replaces the fixed 4-phase divider

---
 rtl/robo_pkg.sv | 34 +++
 rtl/robo_navegador_if.sv | 54 +++++
 rtl/robo_pos_tracker.sv | 75 +++++++
 rtl/robo_navegador.sv | 176 +++++++++++++++++
 tb/tb_robo_navegador.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/robo_pkg.sv
// Shared types for the pipe-cleaner robot navigation controller:
// headings, FSM state encoding, the action chosen in DECIDE and the turn helper.
package robo_pkg;

  typedef enum logic [1:0] {
    NORTE = 2'd0,
    LESTE = 2'd1,
    SUL   = 2'd2,
    OESTE = 2'd3
  } orient_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SENSE  = 3'd1,
    DECIDE = 3'd2,
    ACT    = 3'd3,
    REMOVE = 3'd4,
    DONE   = 3'd5,
    STUCK  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    A_NONE  = 2'd0,
    A_LEFT  = 2'd1,
    A_RIGHT = 2'd2,
    A_ADV   = 2'd3
  } action_t;

  // Heading after a 90 degree turn; the 2-bit wrap gives the mod-4 arithmetic.
  function automatic logic [1:0] turn_heading(input logic [1:0] o, input logic esq);
    return esq ? (o - 2'd1) : (o + 2'd1);
  endfunction

endpackage

// File: rtl/robo_navegador_if.sv
// Sensor/actuator bundle of the navigation controller.
// Optional macro ROBO_STEP_COUNT_EN adds the step_cnt signal.
// Handshake: there is none; start is a level sampled only in IDLE, and
// avancar/girar are single-cycle strobes, girar_esq qualifies girar.
interface robo_navegador_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
`ifdef ROBO_STEP_COUNT_EN
  , parameter int STEP_W = 8
`endif
);
  import robo_pkg::*;

  logic           start;
  logic           head;
  logic           left;
  logic           under;
  logic           barreira;
  logic           avancar;
  logic           girar;
  logic           girar_esq;
  logic           remover;
  logic [1:0]     orient;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           busy;
  logic           done;
  logic           stuck;
  state_t         dbg_state;
`ifdef ROBO_STEP_COUNT_EN
  logic [STEP_W-1:0] step_cnt;
`endif

  // Environment / test side
  modport master (
    output start, head, left, under, barreira,
    input  avancar, girar, girar_esq, remover, orient, pos_x, pos_y,
           busy, done, stuck, dbg_state
`ifdef ROBO_STEP_COUNT_EN
    , input step_cnt
`endif
  );

  // Controller side
  modport slave (
    input  start, head, left, under, barreira,
    output avancar, girar, girar_esq, remover, orient, pos_x, pos_y,
           busy, done, stuck, dbg_state
`ifdef ROBO_STEP_COUNT_EN
    , output step_cnt
`endif
  );

endinterface

// File: rtl/robo_pos_tracker.sv
// Holds heading and grid position, flags when the cell ahead is off-grid,
// and applies the turn/advance chosen by the FSM during its ACT cycle.
module robo_pos_tracker
  import robo_pkg::*;
#(
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int X0      = 0,
  parameter int Y0      = 0,
  parameter int ORIENT0 = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           apply_i,
  input  action_t        action_i,
  output logic [1:0]     orient_o,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic           edge_ahead_o
);

  logic [1:0]     orient_q, orient_d;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d;

  // Pose register, loaded with the start pose on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      orient_q <= 2'(ORIENT0);
      pos_x_q  <= X_W'(X0);
      pos_y_q  <= Y_W'(Y0);
    end else begin
      orient_q <= orient_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  // Next pose; the FSM never selects an advance into an edge, so no wrap happens
  always_comb begin
    orient_d = orient_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    if (apply_i) begin
      case (action_i)
        A_LEFT:  orient_d = turn_heading(orient_q, 1'b1);
        A_RIGHT: orient_d = turn_heading(orient_q, 1'b0);
        A_ADV: begin
          case (orient_q)
            NORTE:   pos_y_d = pos_y_q + Y_W'(1);
            LESTE:   pos_x_d = pos_x_q + X_W'(1);
            SUL:     pos_y_d = pos_y_q - Y_W'(1);
            default: pos_x_d = pos_x_q - X_W'(1);
          endcase
        end
        default: ;
      endcase
    end
  end

  // Grid border ahead counts as a wall
  always_comb begin
    case (orient_q)
      NORTE:   edge_ahead_o = (pos_y_q == '1);
      LESTE:   edge_ahead_o = (pos_x_q == '1);
      SUL:     edge_ahead_o = (pos_y_q == '0);
      default: edge_ahead_o = (pos_x_q == '0);
    endcase
  end

  assign orient_o = orient_q;
  assign pos_x_o  = pos_x_q;
  assign pos_y_o  = pos_y_q;

endmodule

// File: rtl/robo_navegador.sv
// Left-hand wall-follower navigation FSM for the pipe-cleaner robot.
// Optional macro ROBO_STEP_COUNT_EN adds a saturating step counter (step_cnt).
module robo_navegador
  import robo_pkg::*;
#(
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int ORIENT0    = 0,
  parameter int SETTLE_CYC = 2,
  parameter int REMOVE_CYC = 3,
  parameter int MAX_TURNS  = 4
`ifdef ROBO_STEP_COUNT_EN
  , parameter int STEP_W   = 8
`endif
) (
  input logic             clock,
  input logic             reset,
  robo_navegador_if.slave bus
);

  localparam int CNT_MAX = (SETTLE_CYC > REMOVE_CYC) ? SETTLE_CYC : REMOVE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TURN_W  = $clog2(MAX_TURNS + 1);

  state_t            state_q, state_d;
  action_t           action_q, action_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              jtl_q, jtl_d;
  logic              head_q, head_d, left_q, left_d;
  logic              under_q, under_d, barr_q, barr_d;
  logic              edge_ahead;

  // FSM and decision-context registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      action_q <= A_NONE;
      cnt_q    <= '0;
      turn_q   <= '0;
      jtl_q    <= 1'b0;
      head_q   <= 1'b0;
      left_q   <= 1'b0;
      under_q  <= 1'b0;
      barr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      jtl_q    <= jtl_d;
      head_q   <= head_d;
      left_q   <= left_d;
      under_q  <= under_d;
      barr_q   <= barr_d;
    end
  end

  // Next state: sense, decide by priority, act, and track the turn streak
  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    cnt_d    = cnt_q;
    turn_d   = turn_q;
    jtl_d    = jtl_q;
    head_d   = head_q;
    left_d   = left_q;
    under_d  = under_q;
    barr_d   = barr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SENSE;
          cnt_d   = '0;
        end
      end
      SENSE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          head_d  = bus.head;
          left_d  = bus.left;
          under_d = bus.under;
          barr_d  = bus.barreira;
          cnt_d   = '0;
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECIDE: begin
        if (under_q) begin
          state_d = DONE;
        end else if (barr_q) begin
          state_d = REMOVE;
          cnt_d   = '0;
        end else begin
          state_d = ACT;
          if (!left_q && !jtl_q)          action_d = A_LEFT;
          else if (head_q || edge_ahead)  action_d = A_RIGHT;
          else                            action_d = A_ADV;
        end
      end
      ACT: begin
        case (action_q)
          A_LEFT: begin
            jtl_d  = 1'b1;
            turn_d = turn_q + TURN_W'(1);
          end
          A_RIGHT: begin
            jtl_d  = 1'b0;
            turn_d = turn_q + TURN_W'(1);
          end
          A_ADV: begin
            jtl_d  = 1'b0;
            turn_d = '0;
          end
          default: ;
        endcase
        cnt_d   = '0;
        state_d = (turn_d == TURN_W'(MAX_TURNS)) ? STUCK : SENSE;
      end
      REMOVE: begin
        if (cnt_q == CNT_W'(REMOVE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = SENSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = DONE;
      STUCK:   state_d = STUCK;
      default: state_d = IDLE;
    endcase
  end

  robo_pos_tracker #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .X0     (X0),
    .Y0     (Y0),
    .ORIENT0(ORIENT0)
  ) u_pos (
    .clock       (clock),
    .reset       (reset),
    .apply_i     (state_q == ACT),
    .action_i    (action_q),
    .orient_o    (bus.orient),
    .pos_x_o     (bus.pos_x),
    .pos_y_o     (bus.pos_y),
    .edge_ahead_o(edge_ahead)
  );

  // Outputs decode straight from the state register so reset clears them at once
  assign bus.avancar   = (state_q == ACT) && (action_q == A_ADV);
  assign bus.girar     = (state_q == ACT) && ((action_q == A_LEFT) || (action_q == A_RIGHT));
  assign bus.girar_esq = (state_q == ACT) && (action_q == A_LEFT);
  assign bus.remover   = (state_q == REMOVE);
  assign bus.busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != STUCK);
  assign bus.done      = (state_q == DONE);
  assign bus.stuck     = (state_q == STUCK);
  assign bus.dbg_state = state_q;

`ifdef ROBO_STEP_COUNT_EN
  logic [STEP_W-1:0] step_q;

  // Saturating count of forward moves
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          step_q <= '0;
    else if (bus.avancar && step_q != '1) step_q <= step_q + STEP_W'(1);
  end

  assign bus.step_cnt = step_q;
`endif

endmodule

// File: tb/tb_robo_navegador.sv
// Directed bench for robo_navegador: expected pulse events are queued by the
// stimulus and popped by a monitor on every observed pulse / remover burst.
module tb_robo_navegador;
  import robo_pkg::*;

  localparam int EW = 13;  // {kind[1:0], esq, orient[1:0], x[3:0], y[3:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [EW-1:0] exp_q[$];
  int   rem_run = 0;

  robo_navegador_if bus ();

  robo_navegador dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input logic esq,
                                       input logic [1:0] o, input logic [3:0] x,
                                       input logic [3:0] y);
    return {kind, esq, o, x, y};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.head = 1'b0; bus.left = 1'b0;
    bus.under = 1'b0; bus.barreira = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // which: 0 avancar, 1 girar, 2 remover, 3 stuck, 4 done
  task automatic wait_sig(input int which, input int budget, input string name, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = bus.avancar;
        1: hit = bus.girar;
        2: hit = bus.remover;
        3: hit = bus.stuck;
        default: hit = bus.done;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: waited %0d cycles, event required", name, n);
    end
  endtask

  // monitor: every pulse and every finished remover burst must match the queue head
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic          have;
    have = 1'b0;
    got  = '0;
    if (bus.avancar && bus.girar) begin
      checks++;
      errors++;
      $display("FAIL overlap: avancar and girar both 1, required exclusive");
    end
    if (bus.avancar) begin
      got = ev(2'd1, 1'b0, bus.orient, bus.pos_x, bus.pos_y); have = 1'b1;
    end else if (bus.girar) begin
      got = ev(2'd2, bus.girar_esq, bus.orient, bus.pos_x, bus.pos_y); have = 1'b1;
    end
    if (bus.remover) begin
      rem_run++;
    end else if (rem_run > 0) begin
      got = ev(2'd3, 1'b0, 2'd0, 4'(rem_run), 4'd0); have = 1'b1;
      rem_run = 0;
    end
    if (have) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h, queue empty", got);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL event: got %h expected %h", got, e);
        end
      end
    end
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.head = 1'b0; bus.left = 1'b0;
    bus.under = 1'b0; bus.barreira = 1'b0;

    // reset state
    do_reset();
    check("rst_state", bus.dbg_state, IDLE);
    check("rst_orient", bus.orient, 0);
    check("rst_pos_x", bus.pos_x, 0);
    check("rst_pos_y", bus.pos_y, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stuck", bus.stuck, 0);
    check("rst_pulses", {bus.avancar, bus.girar, bus.remover}, 0);
`ifdef ROBO_STEP_COUNT_EN
    check("rst_step", bus.step_cnt, 0);
`endif

    // 1: open field, left turn then edge forces right turn, repeats until stuck
    exp_q.push_back(ev(2'd2, 1'b1, 2'd0, 4'd0, 4'd0));
    exp_q.push_back(ev(2'd2, 1'b0, 2'd3, 4'd0, 4'd0));
    exp_q.push_back(ev(2'd2, 1'b1, 2'd0, 4'd0, 4'd0));
    exp_q.push_back(ev(2'd2, 1'b0, 2'd3, 4'd0, 4'd0));
    pulse_start();
    check("t1_busy", bus.busy, 1);
    wait_sig(3, 40, "t1_stuck", n);
    check("t1_stuck", bus.stuck, 1);
    check("t1_orient", bus.orient, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: turn right to face E, then corridor advances every 4 cycles
    do_reset();
    bus.head = 1'b1; bus.left = 1'b1;
    exp_q.push_back(ev(2'd2, 1'b0, 2'd0, 4'd0, 4'd0));
    exp_q.push_back(ev(2'd1, 1'b0, 2'd1, 4'd0, 4'd0));
    exp_q.push_back(ev(2'd1, 1'b0, 2'd1, 4'd1, 4'd0));
    exp_q.push_back(ev(2'd1, 1'b0, 2'd1, 4'd2, 4'd0));
    pulse_start();
    wait_sig(1, 20, "t2_turn", n);
    bus.head = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_sig(0, 20, "t2_adv", n);
      if (k > 0) check("t2_adv_spacing", n, 4);
    end
    @(negedge clk);
    check("t2_pos_x", bus.pos_x, 3);
    check("t2_orient", bus.orient, 1);
`ifdef ROBO_STEP_COUNT_EN
    check("t2_step", bus.step_cnt, 3);
`endif
    check("t2_q_empty", exp_q.size(), 0);

    // 3: debris at first sense, removed for 3 cycles, then advance
    do_reset();
    bus.left = 1'b1; bus.barreira = 1'b1;
    exp_q.push_back(ev(2'd3, 1'b0, 2'd0, 4'd3, 4'd0));
    exp_q.push_back(ev(2'd1, 1'b0, 2'd0, 4'd0, 4'd0));
    pulse_start();
    wait_sig(2, 20, "t3_remove", n);
    bus.barreira = 1'b0;
    check("t3_pos_y_during", bus.pos_y, 0);
    wait_sig(0, 20, "t3_adv", n);
    @(negedge clk);
    check("t3_pos_y", bus.pos_y, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: enclosed cell, four right turns then stuck, start ignored
    do_reset();
    bus.head = 1'b1; bus.left = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(ev(2'd2, 1'b0, 2'(k), 4'd0, 4'd0));
    pulse_start();
    wait_sig(3, 40, "t4_stuck", n);
    check("t4_stuck", bus.stuck, 1);
    check("t4_busy", bus.busy, 0);
    check("t4_orient", bus.orient, 0);
    pulse_start();
    repeat (10) @(negedge clk);
    check("t4_still_stuck", bus.dbg_state, STUCK);
    check("t4_q_empty", exp_q.size(), 0);

    // 5: target and debris together, target wins
    do_reset();
    bus.under = 1'b1; bus.barreira = 1'b1;
    pulse_start();
    wait_sig(4, 20, "t5_done", n);
    check("t5_done", bus.done, 1);
    check("t5_busy", bus.busy, 0);
    check("t5_remover", bus.remover, 0);
    pulse_start();
    repeat (6) @(negedge clk);
    check("t5_still_done", bus.dbg_state, DONE);
    check("t5_stuck", bus.stuck, 0);

    // 6: reset during the second remover cycle
    do_reset();
    bus.left = 1'b1;
    exp_q.push_back(ev(2'd1, 1'b0, 2'd0, 4'd0, 4'd0));
    exp_q.push_back(ev(2'd3, 1'b0, 2'd0, 4'd2, 4'd0));
    pulse_start();
    wait_sig(0, 20, "t6_adv", n);
    bus.barreira = 1'b1;
    wait_sig(2, 20, "t6_remove", n);
    check("t6_pos_y_before", bus.pos_y, 1);
`ifdef ROBO_STEP_COUNT_EN
    check("t6_step_before", bus.step_cnt, 1);
`endif
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_remover_async", bus.remover, 0);
    check("t6_state", bus.dbg_state, IDLE);
    check("t6_pos_x", bus.pos_x, 0);
    check("t6_pos_y", bus.pos_y, 0);
    check("t6_orient", bus.orient, 0);
`ifdef ROBO_STEP_COUNT_EN
    check("t6_step", bus.step_cnt, 0);
`endif
    do_reset();
    check("t6_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
